// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: state encoding and the
// address/data width defaults that match the datapath (ALUOut, SrcA, ReadData).
package mem_access_ctrl_pkg;

  localparam int unsigned AW_DEF      = 8;   // ALUOut width
  localparam int unsigned DW_DEF      = 8;   // ReadData / SrcA width
  localparam int unsigned TIMEOUT_DEF = 15;  // max REQ cycles before abort
  localparam int unsigned CNT_W       = 4;   // wait counter width

  // Sequencer states; encoding is fixed so it lines up with the datapath docs.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// REQ wait counter with terminal-count compare. Used by mem_access_ctrl only
// when MEM_TIMEOUT_EN is defined. o_expire fires in the REQ cycle whose
// increment would bring the count to TIMEOUT, so the request is held for
// exactly TIMEOUT cycles before it is abandoned.
module mem_wait_timer
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // Wait counter: cleared outside REQ, so it starts from zero on every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = i_inc & (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the datapath and the data RAM.
// Latches the address/store data on a request, runs a req/ack handshake with
// the RAM, registers the load result, and stalls the PC/register write until
// the access retires in DONE.
// Optional feature: define MEM_TIMEOUT_EN to abort a request that has waited
// TIMEOUT cycles without ack (ReadData <= all-ones for a load, err pulses).
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] ReadData,
  output logic          stall,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  logic [DW-1:0] r_rdata;
  logic          w_start;
  logic          w_ack_ok;
  logic          w_abort;
  logic          w_expire;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the one-cycle event strobes for the datapath regs.
  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_ack_ok = 1'b0;
    w_abort  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (mem_read | mem_write) begin
          w_start = 1'b1;
          w_next  = S_REQ;
        end
      end
      S_REQ: begin
        // An ack in the very first REQ cycle is accepted; ack wins over expiry.
        if (mem_ack) begin
          w_ack_ok = 1'b1;
          w_next   = S_DONE;
        end else if (w_expire) begin
          w_abort = 1'b1;
          w_next  = S_DONE;
        end
      end
      S_DONE: begin
        // Request inputs still belong to the retiring instruction: ignore them.
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Access latches and the load result register.
  // A store (including read+write together) never touches r_rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_start) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_we    <= mem_write;
      end
      if (w_ack_ok && !r_we) begin
        r_rdata <= mem_rdata;
      end else if (w_abort && !r_we) begin
        r_rdata <= '1;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic r_err;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state != S_REQ),
    .i_inc    ((r_state == S_REQ) & ~mem_ack),
    .o_expire (w_expire)
  );

  // Abort pulse: high for the single DONE cycle that follows an expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_abort;
    end
  end

  assign err = r_err;
`else
  logic w_unused_timeout;

  assign w_expire         = 1'b0;
  assign err              = 1'b0;
  assign w_unused_timeout = |TIMEOUT;
`endif

  // mem_req is decoded straight from the state so an async reset drops it at
  // once; a late ack then lands in IDLE and is ignored.
  assign mem_req   = (r_state == S_REQ);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign ReadData  = r_rdata;
  assign stall     = ((r_state == S_IDLE) & (mem_read | mem_write)) | (r_state == S_REQ);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. The driver issues accesses and
// acts as the RAM; each access pushes its expected outcome into a queue that
// a negedge monitor pops when the request appears and settles at retirement.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 15;

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic       exp_err;
    int         exp_stall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read, mem_write;
  logic [7:0] addr, wdata;
  logic [7:0] ReadData;
  logic       stall, err, mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ack;

  int         n_checks = 0;
  int         n_err    = 0;
  exp_t       exp_q[$];
  logic [7:0] model_rd;

  // monitor-only state
  exp_t       cur;
  bit         have_cur;
  bit         prev_req;
  int         stall_cnt;

  mem_access_ctrl #(.AW(8), .DW(8), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .ReadData  (ReadData),
    .stall     (stall),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expectation when mem_req rises, checks the latched
  // request every REQ cycle, and checks the retirement in the DONE cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      have_cur  = 1'b0;
      prev_req  = 1'b0;
      stall_cnt = 0;
    end else begin
      if (stall) stall_cnt++;
      if (mem_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_req actual=mem_req_1 expected=no_request at %0t", $time);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (mem_req && have_cur) begin
        check("mem_addr", 32'(mem_addr), 32'(cur.addr));
        check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
        check("mem_we", 32'(mem_we), 32'(cur.we));
      end
      if (!mem_req && prev_req && have_cur) begin
        check("readdata", 32'(ReadData), 32'(cur.exp_rd));
        check("stall_done", 32'(stall), 32'd0);
        check("err_done", 32'(err), 32'(cur.exp_err));
        check("stall_cycles", 32'(stall_cnt), 32'(cur.exp_stall));
        have_cur  = 1'b0;
        stall_cnt = 0;
      end else begin
        check("err_quiet", 32'(err), 32'd0);
      end
      prev_req = mem_req;
    end
  end

  // One access; delay<0 means the RAM never acks. Starts and ends at
  // posedge+1 with the DUT in IDLE. hold leaves the request inputs asserted.
  task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input int delay, input logic [7:0] rdata, input bit hold);
    exp_t e;
    bit   got;
    int   n;
    e.addr    = a;
    e.we      = wr;
    e.wdata   = d;
    e.exp_err = 1'b0;
    if (!wr && rd) begin
      if (delay < 0) begin
        model_rd  = 8'hFF;
        e.exp_err = 1'b1;
      end else begin
        model_rd = rdata;
      end
    end
    e.exp_rd    = model_rd;
    e.exp_stall = (delay < 0) ? 1 + TIMEOUT : 2 + delay;
    exp_q.push_back(e);

    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    got       = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (mem_req) begin
        got = 1'b1;
        break;
      end
    end
    check("req_seen", 32'(got), 32'd1);
    if (!hold || !got) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr      = 8'($urandom);
      wdata     = 8'($urandom);
    end
    if (!got) return;
    if (delay >= 0) begin
      repeat (delay) begin
        mem_rdata = 8'($urandom);
        @(posedge clk); #1;
      end
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
    end else begin
      n = 1;
      for (int i = 0; i < 40 && mem_req; i++) begin
        @(posedge clk); #1;
        if (mem_req) n++;
      end
      check("timeout_req_cycles", 32'(n), 32'(TIMEOUT));
    end
    @(posedge clk); #1;
  endtask

  task automatic quiet_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check("no_req_idle", 32'(mem_req), 32'd0);
    end
  endtask

  // Reset asserted during REQ, then a late ack after release.
  task automatic reset_mid_access();
    exp_t e;
    bit   got;
    e.addr      = 8'h5A;
    e.we        = 1'b0;
    e.wdata     = 8'h00;
    e.exp_rd    = 8'h00;
    e.exp_err   = 1'b0;
    e.exp_stall = 0;
    exp_q.push_back(e);
    mem_read = 1'b1;
    addr     = 8'h5A;
    wdata    = 8'h00;
    got      = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (mem_req) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_req_seen", 32'(got), 32'd1);
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    model_rd = 8'h00;
    check("rst_req_drop", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_readdata", 32'(ReadData), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 8'h77;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_rd", 32'(ReadData), 32'(model_rd));
    check("late_ack_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   rd, wr;
    int   sel;
    rst_n     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = 8'h00;
    wdata     = 8'h00;
    mem_rdata = 8'h00;
    mem_ack   = 1'b0;
    model_rd  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", 32'(ReadData), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // load, ack in the first REQ cycle
    access(1'b1, 1'b0, 8'h10, 8'h00, 0, 8'hA5, 1'b0);
    // store with a slow ack; inputs scrambled during REQ
    access(1'b0, 1'b1, 8'h22, 8'h3C, 4, 8'h99, 1'b0);
    // load with mem_read held through DONE, then released: no second request
    access(1'b1, 1'b0, 8'h31, 8'h00, 1, 8'h5C, 1'b1);
    mem_read = 1'b0;
    quiet_cycles(3);
    // held into IDLE: a second access starts back to back
    access(1'b1, 1'b0, 8'h40, 8'h00, 0, 8'h11, 1'b1);
    access(1'b1, 1'b0, 8'h40, 8'h00, 2, 8'h22, 1'b0);
    // read and write together: store only
    access(1'b1, 1'b1, 8'h55, 8'hC3, 2, 8'hEE, 1'b0);

    // randomized mix with spurious acks while idle
    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 2));
      rd  = (sel != 1);
      wr  = (sel != 0);
      access(rd, wr, 8'($urandom), 8'($urandom), int'($urandom_range(0, 5)), 8'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'($urandom);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("stray_ack_rd", 32'(ReadData), 32'(model_rd));
      end
    end

    reset_mid_access();
    access(1'b1, 1'b0, 8'h66, 8'h00, 1, 8'h3E, 1'b0);

`ifdef MEM_TIMEOUT_EN
    // load that is never acked: abort after TIMEOUT REQ cycles
    access(1'b1, 1'b0, 8'h70, 8'h00, -1, 8'h00, 1'b0);
    access(1'b0, 1'b1, 8'h71, 8'h12, 0, 8'h00, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
